// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL with
// a valid/busy/done handshake so the pipeline can stall while a multiply runs.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] p_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] step_d;
  logic [WIDTH-1:0] first_pp_d;

  // Single-cycle op result, next accumulator value and the bit-0 partial product
  always_comb begin
    alu_d = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_d = data1_i & data2_i;
      OP_OR:   alu_d = data1_i | data2_i;
      OP_ADD:  alu_d = data1_i + data2_i;
      OP_SUB:  alu_d = data1_i - data2_i;
      default: alu_d = '0;
    endcase
    if (q_q[0]) begin
      step_d = p_q + m_q;
    end else begin
      step_d = p_q;
    end
    if (data2_i[0]) begin
      first_pp_d = data1_i;
    end else begin
      first_pp_d = '0;
    end
  end

  // Control FSM and datapath registers. The bit-0 partial product is folded
  // into the accept edge so the multiply holds busy for exactly WIDTH-1 cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      m_q      <= '0;
      q_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              m_q     <= data1_i << 1;
              q_q     <= data2_i >> 1;
              p_q     <= first_pp_d;
              cnt_q   <= CW'(1);
              busy_q  <= 1'b1;
              state_q <= ST_MUL;
            end else begin
              result_q <= alu_d;
              zero_q   <= (alu_d == '0);
              done_q   <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL: begin
          m_q   <= m_q << 1;
          q_q   <= q_q >> 1;
          p_q   <= step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q <= step_d;
            zero_q   <= (step_d == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            state_q <= ST_MUL;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule
